// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - N-channel arbiter sharing one asynchronous SRAM
// Each granted access runs IDLE -> SETUP -> STROBE x WAIT_CYCLES -> HOLD.
module mem_arbiter #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int NUM_CH      = 2,
  parameter int WAIT_CYCLES = 1,
  parameter int PRIO_MODE   = 0
) (
  input  logic                       mai_clk,
  input  logic                       mai_rst,
  input  logic [NUM_CH-1:0]          mai_req,
  input  logic [NUM_CH-1:0]          mai_we,
  input  logic [NUM_CH*ADDR_W-1:0]   mai_addr,
  input  logic [NUM_CH*DATA_W-1:0]   mai_wdata,
  output logic [NUM_CH-1:0]          mao_ack,
  output logic [NUM_CH-1:0]          mao_stall,
  output logic [DATA_W-1:0]          mao_rdata,
  output logic                       mao_ram_en,
  output logic                       mao_ram_oe,
  output logic                       mao_ram_we,
  output logic [ADDR_W-1:0]          mao_ram_addr,
  output logic [DATA_W-1:0]          mao_ram_wdata,
  output logic                       mao_ram_data_oe,
  input  logic [DATA_W-1:0]          mai_ram_rdata
);

  localparam int         IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t           state_q, state_nxt;
  logic [IDX_W-1:0] grant_q, grant_nxt;
  logic [IDX_W-1:0] ptr_q, ptr_inc;
  logic [IDX_W-1:0] win_idx, cand;
  logic             win_found;
  logic             we_q, we_nxt;
  logic [3:0]       cnt_q, cnt_nxt;
  logic             ram_en_nxt, ram_oe_nxt, ram_we_nxt, data_oe_nxt;
  logic [NUM_CH-1:0] ack_nxt;
  int               rr_j;

  // Winner select; loops run from the far end so the preferred index is assigned last.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    rr_j      = 0;
    if (PRIO_MODE == 0) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (mai_req[i]) begin
          win_idx   = IDX_W'(i);
          win_found = 1'b1;
        end
      end
    end else begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        rr_j = int'(ptr_q) + k;
        if (rr_j >= NUM_CH) rr_j = rr_j - NUM_CH;
        cand = IDX_W'(rr_j);
        if (mai_req[cand]) begin
          win_idx   = cand;
          win_found = 1'b1;
        end
      end
    end
  end

  assign ptr_inc = (grant_q == LAST_CH) ? '0 : grant_q + 1'b1;

  // Outputs are registered from the next state, so SRAM pins change on state entry.
  always_comb begin
    state_nxt = state_q;
    grant_nxt = grant_q;
    we_nxt    = we_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_nxt = SETUP;
          grant_nxt = win_idx;
          we_nxt    = mai_we[win_idx];
        end
      end
      SETUP: begin
        state_nxt = STROBE;
        cnt_nxt   = CNT_LOAD;
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          state_nxt = HOLD;
        end else begin
          cnt_nxt = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    ram_en_nxt  = (state_nxt == IDLE);
    ram_oe_nxt  = !((state_nxt == STROBE) && !we_nxt);
    ram_we_nxt  = !((state_nxt == STROBE) && we_nxt);
    data_oe_nxt = we_nxt && (state_nxt != IDLE);
    ack_nxt     = '0;
    if (state_nxt == HOLD) ack_nxt[grant_nxt] = 1'b1;
  end

  always_ff @(posedge mai_clk) begin
    if (mai_rst) begin
      state_q         <= IDLE;
      grant_q         <= '0;
      ptr_q           <= '0;
      we_q            <= 1'b0;
      cnt_q           <= 4'd0;
      mao_ack         <= '0;
      mao_rdata       <= '0;
      mao_ram_en      <= 1'b1;
      mao_ram_oe      <= 1'b1;
      mao_ram_we      <= 1'b1;
      mao_ram_addr    <= '0;
      mao_ram_wdata   <= '0;
      mao_ram_data_oe <= 1'b0;
    end else begin
      state_q         <= state_nxt;
      grant_q         <= grant_nxt;
      we_q            <= we_nxt;
      cnt_q           <= cnt_nxt;
      mao_ack         <= ack_nxt;
      mao_ram_en      <= ram_en_nxt;
      mao_ram_oe      <= ram_oe_nxt;
      mao_ram_we      <= ram_we_nxt;
      mao_ram_data_oe <= data_oe_nxt;
      if (state_q == IDLE && win_found) begin
        mao_ram_addr  <= mai_addr[win_idx*ADDR_W +: ADDR_W];
        mao_ram_wdata <= mai_wdata[win_idx*DATA_W +: DATA_W];
      end
      // Capture on the edge that ends the last strobe cycle.
      if (state_q == STROBE && cnt_q == 4'd0 && !we_q) begin
        mao_rdata <= mai_ram_rdata;
      end
      if (state_q == HOLD) begin
        ptr_q <= ptr_inc;
      end
    end
  end

  assign mao_stall = mai_req & ~mao_ack;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised N-channel arbiter that lets pipeline requesters (IF fetch, MEM load/store, later DMA/UART) share one asynchronous SRAM chip.
- Grants one requester at a time and runs a multi-cycle SRAM read or write sequence with a programmable strobe width.
- Returns one-cycle acks and per-channel stall lines to the pipeline scheduler.
- Replaces the fixed one-RAM-per-stage split in the cpu top level.

Parameters:
DATA_W, 16, SRAM data width
ADDR_W, 16, SRAM address width
NUM_CH, 2, number of requester channels (2..8)
WAIT_CYCLES, 1, cycles the OE/WE strobe is held low (1..15)
PRIO_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
mai_clk  in  1  clock, rising edge
mai_rst  in  1  reset
mai_req  in  NUM_CH  per-channel access request
mai_we  in  NUM_CH  per-channel 1 = write, 0 = read
mai_addr  in  NUM_CH*ADDR_W  channel i address at [i*ADDR_W +: ADDR_W]
mai_wdata  in  NUM_CH*DATA_W  channel i write data, same packing
mao_ack  out  NUM_CH  one-cycle completion pulse, one-hot
mao_stall  out  NUM_CH  req & ~ack, combinational, to scheduler
mao_rdata  out  DATA_W  last captured read data
mao_ram_en  out  1  SRAM chip enable, active low
mao_ram_oe  out  1  SRAM output enable, active low
mao_ram_we  out  1  SRAM write enable, active low
mao_ram_addr  out  ADDR_W  SRAM address
mao_ram_wdata  out  DATA_W  data to drive onto SRAM bus
mao_ram_data_oe  out  1  tristate enable for the bus driver in the top level
mai_ram_rdata  in  DATA_W  SRAM bus read value

Behaviour:
- Clocking and reset: one clock (mai_clk); reset mai_rst is synchronous and active-high.
- Reset values:
  - ram_en, ram_oe and ram_we are 1.
  - data_oe is 0.
  - ack is all 0.
  - rdata and ram_addr are 0.
  - ram_wdata is 0.
  - FSM is IDLE, strobe counter is 0, round-robin pointer is 0.
- FSM states: IDLE, SETUP, STROBE, HOLD. All outputs except mao_stall are registered.
- IDLE:
  - If any req is high, select a winner. PRIO_MODE 0: lowest index. PRIO_MODE 1: first requesting index at or after the pointer, with wrap.
  - Latch the grant index, we, addr and wdata, then go to SETUP.
  - With no request, stay in IDLE; ram_addr holds its last value.
- SETUP (1 cycle):
  - ram_en = 0, address driven, strobes high.
  - For a write, data_oe = 1 from this cycle.
- STROBE (WAIT_CYCLES cycles, counted down by the strobe counter):
  - Read: ram_oe = 0.
  - Write: ram_we = 0, data_oe = 1.
  - Read data is captured into rdata on the last STROBE edge.
- HOLD (1 cycle):
  - Strobes back to 1; ram_en stays 0; data_oe stays 1 for a write (hold time).
  - ack[grant] = 1 this cycle; rdata is valid from this cycle.
  - Round-robin pointer becomes grant+1 mod NUM_CH.
  - Next state is always IDLE.
- Latency: first req cycle to ack is WAIT_CYCLES+3 cycles. An access occupies WAIT_CYCLES+3 cycles, so back-to-back throughput is one access per WAIT_CYCLES+3 cycles.
- Requester contract:
  - Hold req high until ack, and drop it (or present a new request) in the cycle after ack.
  - A req still high in the cycle after ack is treated as a new access.
- Request dropped after grant: the access completes and ack still pulses. Inputs are latched, so later changes to addr, wdata or we are ignored.
- Simultaneous requests: exactly one grant. Losers keep stall = 1 until their own ack.
- rdata is unchanged by writes and holds until the next read capture.
- Reset mid-access: the next cycle is IDLE with all strobes high and data_oe = 0; no ack is issued for the aborted access.
- Synthesis-time check: NUM_CH = 1 degenerates to a plain SRAM controller, and the pointer stays 0.

Test Plan:
- Fixed mode, WAIT_CYCLES=1, ch0 reads 0x0010 and SRAM model returns 0xBEEF -> ram_oe low exactly 1 cycle, ack[0] at cycle 4 from req, rdata=0xBEEF, stall[0]=1 for cycles 1-3.
- ch1 writes 0x1234 to 0x0020, then ch1 reads 0x0020 -> ram_we low 1 cycle with data_oe=1 over SETUP/STROBE/HOLD, read returns 0x1234, rdata unchanged after the write.
- Fixed mode, ch0 and ch1 request in the same cycle -> ch0 acked first, stall[1]=1 through ch0's access, ch1 acked 4 cycles after ch0.
- PRIO_MODE=1, NUM_CH=3, all req held high for 12 cycles -> grant order 0,1,2,0; each ack 4 cycles apart; ack is never multi-hot.
- WAIT_CYCLES=3 read -> ram_oe low exactly 3 cycles, ack at cycle 6, rdata sampled at end of the third strobe cycle.
- mai_rst asserted during STROBE of a write -> next cycle ram_we=1, ram_en=1, data_oe=0, state IDLE, no ack; a fresh req afterwards completes normally.
